ndc_tri_sequencer: RTL and testbench
====================================

NDC_TRI_SEQUENCER -- requirements
Module: ndc_tri_sequencer

Interface
- REQ-001 Parameters (name, default, meaning), one per line:
  - P_WIDTH, 16, vertex coordinate width.
  - C_WIDTH, 18, camera position width.
  - V_WIDTH, 16, camera basis vector width.
  - NDC_WIDTH, 23, width of each NDC result component.
  - LATENCY, 4, cycles from a transform issue to its result.
  - TIMEOUT, 8, WAIT-state cycle limit.
- REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, clock.
  - rst, in, 1, synchronous active-high reset.
  - tri_valid_in, in, 1, triangle request valid.
  - tri_ready_out, out, 1, triangle request accepted.
  - tri_verts, in, 3x3xP_WIDTH signed, vertices [v][axis].
  - cam_valid_in, in, 1, camera update valid.
  - cam_ready_out, out, 1, camera update accepted.
  - cam_C, in, 3xC_WIDTH signed, camera position.
  - cam_u, in, 3xV_WIDTH signed, camera u vector.
  - cam_v, in, 3xV_WIDTH signed, camera v vector.
  - cam_n, in, 3xV_WIDTH signed, camera n vector.
  - xf_valid_out, out, 1, transform issue strobe.
  - xf_P, out, 3xP_WIDTH signed, vertex being issued.
  - xf_C, out, 3xC_WIDTH signed, latched camera position.
  - xf_u, out, 3xV_WIDTH signed, latched u vector.
  - xf_v, out, 3xV_WIDTH signed, latched v vector.
  - xf_n, out, 3xV_WIDTH signed, latched n vector.
  - xf_valid_in, in, 1, transform result valid.
  - xf_ndc_x, in, NDC_WIDTH signed, result x.
  - xf_ndc_y, in, NDC_WIDTH signed, result y.
  - xf_ndc_z, in, NDC_WIDTH signed, result z.
  - tri_valid_out, out, 1, assembled triangle valid.
  - tri_ready_in, in, 1, downstream accepts triangle.
  - tri_ndc, out, 3x3xNDC_WIDTH signed, NDC results [v][x,y,z].
  - err_out, out, 1, sticky protocol or timeout error.
- REQ-003 The block shall use one clock, clk; reset rst shall be synchronous and active-high.

Function
- REQ-004 The FSM shall have four states: IDLE, ISSUE, WAIT and DONE.
- REQ-005 In IDLE, cam_ready_out shall be 1, and tri_ready_out shall equal the inverse of cam_valid_in; both shall be 0 in every other state.
- REQ-006 When cam_valid_in=1 in IDLE, the camera registers shall latch cam_C, cam_u, cam_v and cam_n, and the FSM shall stay in IDLE.
- REQ-007 A camera update shall take priority over a triangle request offered in the same cycle.
- REQ-008 When tri_valid_in=1 and tri_ready_out=1, the block shall latch tri_verts and enter ISSUE.
- REQ-009 ISSUE shall last exactly 3 cycles, asserting xf_valid_out=1 with xf_P equal to vertex 0, then 1, then 2, and shall then enter WAIT.
- REQ-010 xf_C, xf_u, xf_v and xf_n shall always drive the latched camera registers.
- REQ-011 xf_valid_out shall be 0 outside ISSUE.
- REQ-012 A result counter rcnt (0..3) shall clear on triangle accept.
- REQ-013 Each xf_valid_in=1 in ISSUE or WAIT shall write {x,y,z} to tri_ndc[rcnt] and increment rcnt.
- REQ-014 When rcnt reaches 3, the FSM shall enter DONE on the next edge.
- REQ-015 In DONE, tri_valid_out shall be 1 and tri_ndc shall be stable.
- REQ-016 On tri_valid_out && tri_ready_in, the FSM shall return to IDLE.
- REQ-017 tri_valid_out shall be 0 in every other state.
- REQ-018 Nominal timing: accept at cycle T, issues at T+1..T+3, results at T+1+LATENCY..T+3+LATENCY, and tri_valid_out first high at T+4+LATENCY.
- REQ-019 xf_valid_in=1 in IDLE or DONE shall be ignored (no write), and err_out shall be set.
- REQ-020 A WAIT cycle counter shall run; if it reaches TIMEOUT with rcnt<3, err_out shall be set, the partial triangle discarded, and the FSM returned to IDLE.
- REQ-021 err_out shall be sticky until rst.
- REQ-022 xf_valid_in shall be ignored while rst=1.
- REQ-023 The block shall perform no arithmetic on NDC data, passing it through bit-exact.

Reset
- REQ-024 rst=1 shall force state IDLE, rcnt=0, the WAIT counter to 0, camera registers to 0, tri_ndc to 0, tri_valid_out=0, xf_valid_out=0 and err_out=0.
- REQ-025 Reset asserted mid-ISSUE, mid-WAIT or in DONE shall abort the triangle with no output.
- REQ-026 After reset deasserts, the first IDLE cycle shall offer cam_ready_out=1 and tri_ready_out=1.

Verification
- REQ-027 Nominal: load camera C=0, then a triangle with verts (1,2,3),(4,5,6),(7,8,9); a model returns results LATENCY cycles after each issue -> xf_P sequence matches at T+1..T+3, tri_valid_out rises at T+8 (LATENCY=4) with tri_ndc equal to the three results in order, and err_out=0.
- REQ-028 Priority: cam_valid_in=1 and tri_valid_in=1 in the same IDLE cycle -> camera latched, tri_ready_out=0; the triangle is accepted the next cycle and issued with the new camera on xf_C.
- REQ-029 Backpressure: tri_ready_in held 0 for 10 cycles in DONE -> tri_valid_out and tri_ndc stay constant, tri_ready_out=0, and camera updates are refused until release.
- REQ-030 Timeout: only 2 results returned -> after 8 WAIT cycles err_out=1, state IDLE, tri_valid_out never asserted, and the next triangle completes normally.
- REQ-031 Stray result: xf_valid_in=1 in IDLE -> err_out=1 and tri_ndc unchanged.
- REQ-032 Reset in WAIT after 1 result -> all outputs at reset values the next cycle, and late results are ignored without setting err_out while rst=1.

Source files
------------

// File: rtl/ndc_tri_sequencer_if.sv
// Signal bundle between the triangle sequencer, its camera/triangle sources,
// the external transform unit and the downstream triangle consumer.
interface ndc_tri_sequencer_if #(
    parameter int unsigned P_WIDTH   = 16,
    parameter int unsigned C_WIDTH   = 18,
    parameter int unsigned V_WIDTH   = 16,
    parameter int unsigned NDC_WIDTH = 23
) ();

    logic                           tri_valid_in;
    logic                           tri_ready_out;
    logic [2:0][2:0][P_WIDTH-1:0]   tri_verts;

    logic                           cam_valid_in;
    logic                           cam_ready_out;
    logic [2:0][C_WIDTH-1:0]        cam_C;
    logic [2:0][V_WIDTH-1:0]        cam_u;
    logic [2:0][V_WIDTH-1:0]        cam_v;
    logic [2:0][V_WIDTH-1:0]        cam_n;

    logic                           xf_valid_out;
    logic [2:0][P_WIDTH-1:0]        xf_P;
    logic [2:0][C_WIDTH-1:0]        xf_C;
    logic [2:0][V_WIDTH-1:0]        xf_u;
    logic [2:0][V_WIDTH-1:0]        xf_v;
    logic [2:0][V_WIDTH-1:0]        xf_n;

    logic                           xf_valid_in;
    logic [NDC_WIDTH-1:0]           xf_ndc_x;
    logic [NDC_WIDTH-1:0]           xf_ndc_y;
    logic [NDC_WIDTH-1:0]           xf_ndc_z;

    logic                           tri_valid_out;
    logic                           tri_ready_in;
    logic [2:0][2:0][NDC_WIDTH-1:0] tri_ndc;

    logic                           err_out;

    // Sequencer side
    modport master (
        input  tri_valid_in, tri_verts,
        input  cam_valid_in, cam_C, cam_u, cam_v, cam_n,
        input  xf_valid_in, xf_ndc_x, xf_ndc_y, xf_ndc_z,
        input  tri_ready_in,
        output tri_ready_out, cam_ready_out,
        output xf_valid_out, xf_P, xf_C, xf_u, xf_v, xf_n,
        output tri_valid_out, tri_ndc, err_out
    );

    // Environment side
    modport slave (
        output tri_valid_in, tri_verts,
        output cam_valid_in, cam_C, cam_u, cam_v, cam_n,
        output xf_valid_in, xf_ndc_x, xf_ndc_y, xf_ndc_z,
        output tri_ready_in,
        input  tri_ready_out, cam_ready_out,
        input  xf_valid_out, xf_P, xf_C, xf_u, xf_v, xf_n,
        input  tri_valid_out, tri_ndc, err_out
    );

endinterface

// File: rtl/ndc_tri_sequencer.sv
// Issues the three vertices of a triangle to an external camera transform and
// gathers the three NDC results back into one triangle for the consumer.
module ndc_tri_sequencer #(
    parameter int unsigned P_WIDTH   = 16,
    parameter int unsigned C_WIDTH   = 18,
    parameter int unsigned V_WIDTH   = 16,
    parameter int unsigned NDC_WIDTH = 23,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input logic                 clk,
    input logic                 rst,
    ndc_tri_sequencer_if.master bus
);

    // WAIT counter is sized to cover both the timeout and the nominal result latency
    localparam int unsigned WAIT_SPAN = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
    localparam int unsigned WCNT_W    = $clog2(WAIT_SPAN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_nx;
    logic [1:0]                     icnt;
    logic [1:0]                     rcnt;
    logic [WCNT_W-1:0]              wcnt;
    logic [2:0][2:0][P_WIDTH-1:0]   verts_q;
    logic [2:0][C_WIDTH-1:0]        cam_c_q;
    logic [2:0][V_WIDTH-1:0]        cam_u_q;
    logic [2:0][V_WIDTH-1:0]        cam_v_q;
    logic [2:0][V_WIDTH-1:0]        cam_n_q;
    logic [2:0][2:0][NDC_WIDTH-1:0] ndc_q;
    logic                           err_q;

    logic cam_load_c;
    logic accept_c;
    logic res_take_c;
    logic done_c;
    logic timeout_c;
    logic stray_c;

    // Next-state and per-cycle event decode
    always_comb begin
        state_nx   = state;
        cam_load_c = 1'b0;
        accept_c   = 1'b0;
        res_take_c = 1'b0;
        done_c     = 1'b0;
        timeout_c  = 1'b0;
        stray_c    = 1'b0;
        case (state)
            S_IDLE: begin
                cam_load_c = bus.cam_valid_in;
                accept_c   = bus.tri_valid_in & ~bus.cam_valid_in;
                stray_c    = bus.xf_valid_in;
                if (accept_c) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                res_take_c = bus.xf_valid_in & (rcnt != 2'd3);
                stray_c    = bus.xf_valid_in & (rcnt == 2'd3);
                // The edge that writes the third result also moves to DONE
                done_c     = (rcnt == 2'd3) | (res_take_c & (rcnt == 2'd2));
                if (state == S_ISSUE) begin
                    if (icnt == 2'd2) begin
                        state_nx = done_c ? S_DONE : S_WAIT;
                    end
                end else if (done_c) begin
                    state_nx = S_DONE;
                end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            S_DONE: begin
                stray_c = bus.xf_valid_in;
                if (bus.tri_ready_in) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.cam_ready_out = (state == S_IDLE);
    assign bus.tri_ready_out = (state == S_IDLE) & ~bus.cam_valid_in;
    assign bus.xf_valid_out  = (state == S_ISSUE);
    assign bus.xf_P          = verts_q[icnt];
    assign bus.xf_C          = cam_c_q;
    assign bus.xf_u          = cam_u_q;
    assign bus.xf_v          = cam_v_q;
    assign bus.xf_n          = cam_n_q;
    assign bus.tri_valid_out = (state == S_DONE);
    assign bus.tri_ndc       = ndc_q;
    assign bus.err_out       = err_q;

    // State, counters, camera/vertex latches and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            icnt    <= 2'd0;
            rcnt    <= 2'd0;
            wcnt    <= '0;
            verts_q <= '0;
            cam_c_q <= '0;
            cam_u_q <= '0;
            cam_v_q <= '0;
            cam_n_q <= '0;
            ndc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (cam_load_c) begin
                cam_c_q <= bus.cam_C;
                cam_u_q <= bus.cam_u;
                cam_v_q <= bus.cam_v;
                cam_n_q <= bus.cam_n;
            end
            if (accept_c) begin
                verts_q <= bus.tri_verts;
                icnt    <= 2'd0;
                rcnt    <= 2'd0;
            end else begin
                if (state == S_ISSUE) begin
                    icnt <= (icnt == 2'd2) ? 2'd0 : 2'(icnt + 2'd1);
                end
                if (res_take_c) begin
                    ndc_q[rcnt] <= {bus.xf_ndc_z, bus.xf_ndc_y, bus.xf_ndc_x};
                    rcnt        <= 2'(rcnt + 2'd1);
                end
            end
            wcnt <= (state == S_WAIT) ? WCNT_W'(wcnt + 1'b1) : '0;
            if (stray_c | timeout_c) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ndc_tri_sequencer.sv
// Randomized bench for ndc_tri_sequencer: a latency-accurate transform responder
// plus a triangle-level reference model of camera, results and error flag.
module tb_ndc_tri_sequencer;

    localparam int unsigned P_WIDTH   = 16;
    localparam int unsigned C_WIDTH   = 18;
    localparam int unsigned V_WIDTH   = 16;
    localparam int unsigned NDC_WIDTH = 23;
    localparam int unsigned LATENCY   = 4;
    localparam int unsigned TIMEOUT   = 8;

    typedef logic [2:0][2:0][P_WIDTH-1:0]   verts_t;
    typedef logic [2:0][2:0][NDC_WIDTH-1:0] ndc_t;
    typedef logic [3*NDC_WIDTH-1:0]         res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    ndc_tri_sequencer_if #(
        .P_WIDTH(P_WIDTH), .C_WIDTH(C_WIDTH), .V_WIDTH(V_WIDTH), .NDC_WIDTH(NDC_WIDTH)
    ) bus ();

    ndc_tri_sequencer #(
        .P_WIDTH(P_WIDTH), .C_WIDTH(C_WIDTH), .V_WIDTH(V_WIDTH),
        .NDC_WIDTH(NDC_WIDTH), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [2:0][C_WIDTH-1:0] m_C;
    logic [2:0][V_WIDTH-1:0] m_u, m_v, m_n;
    logic                    exp_err;
    ndc_t                    last_tri;
    int                      sent_rd;

    // Transform responder: answers each issue LATENCY cycles later
    int   pend_due[$];
    res_t sent[$];
    int   tri_id = 0;
    int   tri_limit = 3;
    int   stray_req = 0;
    int   stray_done = 0;
    int   ret_tri = -1;
    int   ret_cnt = 0;

    task automatic drive_result(input bit keep);
        res_t r;
        r = {NDC_WIDTH'($urandom), NDC_WIDTH'($urandom), NDC_WIDTH'($urandom)};
        bus.xf_ndc_x    = r[NDC_WIDTH-1:0];
        bus.xf_ndc_y    = r[2*NDC_WIDTH-1:NDC_WIDTH];
        bus.xf_ndc_z    = r[3*NDC_WIDTH-1:2*NDC_WIDTH];
        bus.xf_valid_in = 1'b1;
        if (keep) sent.push_back(r);
    endtask

    always @(posedge clk) begin
        if (bus.xf_valid_out === 1'b1) pend_due.push_back(cyc + int'(LATENCY));
        #1;
        bus.xf_valid_in = 1'b0;
        while (pend_due.size() > 0 && pend_due[0] < cyc) void'(pend_due.pop_front());
        if (stray_req != stray_done) begin
            stray_done++;
            drive_result(1'b0);
        end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            void'(pend_due.pop_front());
            if (ret_tri != tri_id) begin
                ret_tri = tri_id;
                ret_cnt = 0;
            end
            if (ret_cnt < tri_limit) begin
                ret_cnt++;
                drive_result(1'b1);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_cam(input bit zero_c);
        bus.cam_C = zero_c ? '0 : (3*C_WIDTH)'({$urandom, $urandom});
        bus.cam_u = (3*V_WIDTH)'({$urandom, $urandom});
        bus.cam_v = (3*V_WIDTH)'({$urandom, $urandom});
        bus.cam_n = (3*V_WIDTH)'({$urandom, $urandom});
        bus.cam_valid_in = 1'b1;
        #1;
        check_eq("cam_ready", bus.cam_ready_out, 1'b1);
        check_eq("tri_ready_masked", bus.tri_ready_out, 1'b0);
        tick();
        bus.cam_valid_in = 1'b0;
        m_C = bus.cam_C;
        m_u = bus.cam_u;
        m_v = bus.cam_v;
        m_n = bus.cam_n;
    endtask

    task automatic rand_verts(output verts_t vt);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                vt[v][a] = P_WIDTH'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tri_valid"}, bus.tri_valid_out, 1'b0);
        check_eq({tag, "_xf_valid"}, bus.xf_valid_out, 1'b0);
        check_eq({tag, "_err"}, bus.err_out, 1'b0);
        check_eq({tag, "_tri_ndc"}, bus.tri_ndc, '0);
        check_eq({tag, "_xf_C"}, bus.xf_C, '0);
        check_eq({tag, "_xf_n"}, bus.xf_n, '0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
        check_eq("post_rst_cam_ready", bus.cam_ready_out, 1'b1);
        check_eq("post_rst_tri_ready", bus.tri_ready_out, 1'b1);
        tick();
        m_C = '0; m_u = '0; m_v = '0; m_n = '0;
        exp_err  = 1'b0;
        last_tri = '0;
    endtask

    // One triangle transaction; limit<3 starves the transform, hold>0 backpressures DONE
    task automatic run_tri(input verts_t vt, input int limit, input int hold, output int t_acc);
        ndc_t exp_ndc;
        bit   seen;
        tri_id++;
        tri_limit = limit;
        sent_rd = sent.size();
        bus.tri_verts = vt;
        bus.tri_valid_in = 1'b1;
        bus.tri_ready_in = (hold == 0);
        t_acc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.tri_ready_out) begin
                t_acc = cyc;
                tick();
                break;
            end
            tick();
        end
        bus.tri_valid_in = 1'b0;
        if (t_acc < 0) begin
            check_eq("accept_wait", 1'b0, 1'b1);
            return;
        end
        for (int k = 0; k < 3; k++) begin
            check_eq("xf_valid", bus.xf_valid_out, 1'b1);
            check_eq("xf_P", bus.xf_P, vt[k]);
            check_eq("xf_C", bus.xf_C, m_C);
            if (k == 0) begin
                check_eq("xf_u", bus.xf_u, m_u);
                check_eq("xf_v", bus.xf_v, m_v);
                check_eq("xf_n", bus.xf_n, m_n);
            end
            tick();
        end
        check_eq("xf_valid_after_issue", bus.xf_valid_out, 1'b0);

        if (limit < 3) begin
            seen = 1'b0;
            while (cyc < t_acc + 4 + int'(TIMEOUT) - 1) begin
                seen |= bus.tri_valid_out;
                tick();
            end
            seen |= bus.tri_valid_out;
            check_eq("err_before_timeout", bus.err_out, exp_err);
            tick();
            seen |= bus.tri_valid_out;
            check_eq("err_timeout", bus.err_out, 1'b1);
            check_eq("timeout_idle", bus.cam_ready_out, 1'b1);
            check_eq("timeout_no_tri", seen, 1'b0);
            exp_err = 1'b1;
            return;
        end

        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.tri_valid_out) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("done_seen", seen, 1'b1);
        if (!seen) return;
        check_eq("done_latency", cyc - t_acc, 4 + LATENCY);
        check_eq("results_sent", sent.size() - sent_rd, 3);
        exp_ndc = '0;
        if (sent.size() >= sent_rd + 3)
            exp_ndc = {sent[sent_rd+2], sent[sent_rd+1], sent[sent_rd]};
        check_eq("tri_ndc", bus.tri_ndc, exp_ndc);
        check_eq("err", bus.err_out, exp_err);
        for (int i = 0; i < hold; i++) begin
            check_eq("bp_valid", bus.tri_valid_out, 1'b1);
            check_eq("bp_ndc", bus.tri_ndc, exp_ndc);
            bus.cam_C = (3*C_WIDTH)'({$urandom, $urandom});
            bus.cam_valid_in = 1'b1;
            #1;
            check_eq("bp_tri_ready", bus.tri_ready_out, 1'b0);
            check_eq("bp_cam_ready", bus.cam_ready_out, 1'b0);
            tick();
        end
        bus.cam_valid_in = 1'b0;
        bus.tri_ready_in = 1'b1;
        tick();
        check_eq("done_release", bus.tri_valid_out, 1'b0);
        check_eq("idle_cam_ready", bus.cam_ready_out, 1'b1);
        check_eq("cam_kept", bus.xf_C, m_C);
        last_tri = exp_ndc;
    endtask

    initial begin
        verts_t vt;
        int     t;
        int     c0;
        bus.tri_valid_in = 1'b0;
        bus.tri_verts    = '0;
        bus.cam_valid_in = 1'b0;
        bus.cam_C        = '0;
        bus.cam_u        = '0;
        bus.cam_v        = '0;
        bus.cam_n        = '0;
        bus.tri_ready_in = 1'b1;
        m_C = '0; m_u = '0; m_v = '0; m_n = '0;
        exp_err  = 1'b0;
        last_tri = '0;
        sent_rd  = 0;

        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        release_reset();

        // Nominal triangle with camera at origin
        load_cam(1'b1);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                vt[v][a] = P_WIDTH'(3 * v + a + 1);
        run_tri(vt, 3, 0, t);

        // Camera wins over a simultaneous triangle; triangle accepted next cycle
        rand_verts(vt);
        bus.tri_verts    = vt;
        bus.tri_valid_in = 1'b1;
        bus.cam_C = (3*C_WIDTH)'({$urandom, $urandom});
        bus.cam_u = (3*V_WIDTH)'({$urandom, $urandom});
        bus.cam_v = (3*V_WIDTH)'({$urandom, $urandom});
        bus.cam_n = (3*V_WIDTH)'({$urandom, $urandom});
        bus.cam_valid_in = 1'b1;
        #1;
        check_eq("prio_tri_ready", bus.tri_ready_out, 1'b0);
        check_eq("prio_cam_ready", bus.cam_ready_out, 1'b1);
        tick();
        bus.cam_valid_in = 1'b0;
        m_C = bus.cam_C; m_u = bus.cam_u; m_v = bus.cam_v; m_n = bus.cam_n;
        c0 = cyc;
        run_tri(vt, 3, 0, t);
        check_eq("prio_accept_next", t, c0);

        // Downstream backpressure for 10 cycles
        rand_verts(vt);
        run_tri(vt, 3, 10, t);

        // Random traffic
        repeat (6) begin
            if ($urandom_range(0, 1) == 1) load_cam(1'b0);
            rand_verts(vt);
            run_tri(vt, 3, int'($urandom_range(0, 2)), t);
        end

        // Stray result in IDLE
        stray_req++;
        tick();
        check_eq("stray_err_pre", bus.err_out, 1'b0);
        tick();
        check_eq("stray_err", bus.err_out, 1'b1);
        check_eq("stray_ndc", bus.tri_ndc, last_tri);
        exp_err = 1'b1;

        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset2");
        release_reset();

        // Starved transform times out; next triangle still completes
        load_cam(1'b0);
        rand_verts(vt);
        run_tri(vt, 2, 0, t);
        rand_verts(vt);
        run_tri(vt, 3, 0, t);

        // Reset during WAIT with one result already collected
        rand_verts(vt);
        tri_id++;
        tri_limit = 3;
        bus.tri_verts    = vt;
        bus.tri_valid_in = 1'b1;
        #1;
        check_eq("wrst_accept", bus.tri_ready_out, 1'b1);
        t = cyc;
        tick();
        bus.tri_valid_in = 1'b0;
        while (cyc < t + 6) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("wait_rst");
        tick();
        check_eq("wait_rst_late_err", bus.err_out, 1'b0);
        check_eq("wait_rst_late_ndc", bus.tri_ndc, '0);
        release_reset();

        load_cam(1'b0);
        rand_verts(vt);
        run_tri(vt, 3, 1, t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
